reg_access_master: RTL

- Initiator side of the byte-wide register-file bus (sof/eof/valid/addr/wdata/read/ready/rdata) that the ESC register blocks (FMMU, SyncManager, etc.) respond on.
- Takes one decoded physical-addressed datagram command from the datagram processor and splits it into per-byte register accesses.
- For writes, it draws payload bytes from an input stream; for reads, it returns register bytes on an output stream.
- On completion it pulses done and reports the working-counter increment.

---
 rtl/reg_access_master.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_access_master.sv
`default_nettype none
// ============================================================================
//  Module      : reg_access_master
//  Description : Initiator on the byte-wide register-file bus. Accepts one
//                physical-addressed datagram command (address, length,
//                direction) and breaks it into single-byte register
//                accesses at consecutive addresses.
//                  - Write commands take one payload byte per access from the
//                    in_* stream; a byte is consumed only when the bus
//                    accepts the access carrying it.
//                  - Read commands issue one access at a time. The registered
//                    rdata is captured and offered on the out_* stream, and
//                    the next access waits until that byte has been taken.
//                A completed command pulses done, with wkc_inc flagging a
//                non-empty command. abort drops the command without done.
//  Ports       :
//    clk, rst                    clock, asynchronous active-high reset
//    cmd_valid/cmd_ready         command handshake (ready only when idle)
//    cmd_read/cmd_addr/cmd_len   command direction, first address, byte count
//    abort                       frame error, terminates the active command
//    in_valid/in_data/in_ready   write payload stream
//    out_valid/out_data/out_ready read data stream
//    sof/eof/valid/addr/wdata/read/ready/rdata  register-file bus
//    done/wkc_inc                completion pulse and working-counter flag
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_access_master #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    // command from the datagram processor
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    // write payload stream
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    // read data stream
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    // register-file bus
    output logic              sof,
    output logic              eof,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    output logic              read,
    input  logic              ready,
    input  logic [7:0]        rdata,
    // completion
    output logic              done,
    output logic              wkc_inc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_RD_REQ = 3'd2,
        S_RD_CAP = 3'd3,
        S_RD_OUT = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // The command direction is not stored separately: the WR_* / RD_* state
    // path chosen at capture already carries it.
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_first;     // next accepted access is the first one
    logic               r_len_nz;    // latched command length was non-zero
    logic [7:0]         r_rdata;     // read holding register

    logic               w_cmd_take;
    logic               w_last;      // the access in flight is the final one
    logic               w_bus_acc;   // bus access completes this cycle
    logic               w_step;      // byte finished: advance addr/remaining

    assign w_cmd_take = cmd_valid && (r_state == S_IDLE);
    assign w_last     = (r_remaining == LEN_W'(1));
    assign w_bus_acc  = valid && ready;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        valid       = 1'b0;
        read        = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        wkc_inc     = 1'b0;
        w_step      = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        w_state_nxt = S_FIN;
                    end else if (cmd_read) begin
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_state_nxt = S_WR_REQ;
                    end
                end
            end

            S_WR_REQ: begin
                // The payload byte rides straight onto the bus; the stream
                // only sees it consumed when the responder takes it.
                valid    = in_valid;
                in_ready = ready;
                if (in_valid && ready) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end
                end
            end

            S_RD_REQ: begin
                valid = 1'b1;
                read  = 1'b1;
                if (ready) begin
                    w_state_nxt = S_RD_CAP;
                end
            end

            S_RD_CAP: begin
                // rdata is registered by the responder: it is valid now,
                // one cycle after the read was accepted.
                w_state_nxt = S_RD_OUT;
            end

            S_RD_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? S_FIN : S_RD_REQ;
                end
            end

            S_FIN: begin
                // An abort landing here still ends the command unreported.
                done        = !abort;
                wkc_inc     = r_len_nz && !abort;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over every transition. An access accepted in the same
        // cycle still stands because valid/ready are left untouched here.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Address/data are forced to zero whenever no access is presented so the
    // bus is quiet between commands.
    assign sof      = valid && r_first;
    assign eof      = valid && w_last;
    assign addr     = valid ? r_addr : '0;
    assign wdata    = (valid && !read) ? in_data : 8'h00;
    assign out_data = out_valid ? r_rdata : 8'h00;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_len_nz    <= 1'b0;
            r_rdata     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;

            if (w_cmd_take) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
                r_first     <= 1'b1;
                r_len_nz    <= (cmd_len != '0);
            end

            if (w_bus_acc) begin
                r_first <= 1'b0;
            end

            // Wraps modulo 2^ADDR_W by construction.
            if (w_step) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end

            if (r_state == S_RD_CAP) begin
                r_rdata <= rdata;
            end
        end
    end

endmodule
`default_nettype wire
